serial_add_ctrl: RTL

Bit-serial add sequencer that time-shares a single `full_adder` across a WIDTH-bit operation, one bit per clock, LSB first. It accepts an operand pair on a start pulse, runs the carry through a carry flop for WIDTH cycles, then presents the registered result with a one-cycle `done` pulse. It is the area-minimal arithmetic path feeding the CPU datapath where a WIDTH-wide ripple adder is not justified.

---
 rtl/serial_add_ctrl_if.sv | 39 +++
 rtl/serial_add_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/response bundle for the bit-serial add sequencer.
// The requester drives start, operands and initial carry; the sequencer
// returns busy, the done pulse and the registered result.
// Optional macro SERIAL_ADD_SUB_EN adds the 'sub' request bit.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             carryIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryOut;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;

    modport master (
        output start, in1, in2, carryIn, sub,
        input  busy, done, sum, carryOut
    );

    modport slave (
        input  start, in1, in2, carryIn, sub,
        output busy, done, sum, carryOut
    );
`else
    modport master (
        output start, in1, in2, carryIn,
        input  busy, done, sum, carryOut
    );

    modport slave (
        input  start, in1, in2, carryIn,
        output busy, done, sum, carryOut
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. One full_adder is reused for
// WIDTH cycles, LSB first, with the carry held in a flop between bits.
// The result is registered on the completion edge and flagged by a
// one-cycle done pulse; sum/carryOut hold the previous result meanwhile.
// Optional macro SERIAL_ADD_SUB_EN: adds a 'sub' request bit that turns the
// operation into in1 - in2 (B inverted, carry forced to 1).

// Single-bit full adder; the only arithmetic element of the datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             load_s;
    logic             step_s;
    logic             finish_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             c_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH-1:0] a_shift_s;
    logic [WIDTH-1:0] b_shift_s;
    logic [WIDTH-1:0] s_shift_s;
    logic [WIDTH-1:0] b_load_s;
    logic             c_load_s;
    logic             fa_sum_s;
    logic             fa_cout_s;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_out_r;

    full_adder u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (c_r),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Operand selection at load time; subtract mode inverts B and injects carry 1.
    always_comb begin
        b_load_s = bus.in2;
        c_load_s = bus.carryIn;
`ifdef SERIAL_ADD_SUB_EN
        if (bus.sub) begin
            b_load_s = ~bus.in2;
            c_load_s = 1'b1;
        end else begin
            b_load_s = bus.in2;
            c_load_s = bus.carryIn;
        end
`endif
    end

    // Shift-register next values: operands move right, new sum bit enters at the MSB.
    always_comb begin
        a_shift_s            = a_r >> 1;
        b_shift_s            = b_r >> 1;
        s_shift_s            = s_r >> 1;
        s_shift_s[WIDTH-1]   = fa_sum_s;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and datapath control; start is only honoured when not running.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    load_s       = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    finish_s     = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load_s       = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Serial datapath: load operands on accept, then process one bit per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            s_r   <= '0;
            c_r   <= 1'b0;
            cnt_r <= '0;
        end else if (load_s) begin
            a_r   <= bus.in1;
            b_r   <= b_load_s;
            s_r   <= '0;
            c_r   <= c_load_s;
            cnt_r <= '0;
        end else if (step_s) begin
            a_r   <= a_shift_s;
            b_r   <= b_shift_s;
            s_r   <= s_shift_s;
            c_r   <= fa_cout_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Registered outputs: result captured only on the completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == RUN);
            done_r <= finish_s;
            if (finish_s) begin
                sum_r       <= s_shift_s;
                carry_out_r <= fa_cout_s;
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_r;
    assign bus.carryOut = carry_out_r;

endmodule
